instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Decoupled instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute datapath. It issues word-aligned fetch requests to an instruction memory with variable latency and a valid/ready handshake. Returned instructions are buffered with their PCs in a small in-order queue and presented to the core over a valid/ready interface. Branch/jump redirects from execute flush the queue and discard any responses still in flight.

Parameters:
DEPTH, 4, entries in instruction queue and maximum in-flight requests; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
redirect_valid  in  1  redirect request from execute (taken branch or jump)
redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address, word aligned
imem_rsp_valid  in  1  response valid; in order; never back-pressured
imem_rsp_data  in  32  fetched instruction
out_valid  out  1  queue head valid
out_ready  in  1  core consumes head
out_pc  out  32  PC of head instruction
out_instr  out  32  head instruction

Behaviour:
- Reset (rst=0 at clock edge): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=FETCH. While reset is asserted, imem_req_valid=0 and out_valid=0. A reset asserted mid-operation abandons all state. Responses that arrive after reset for pre-reset requests are a system error and are out of scope.
- States: FETCH (issue requests, enqueue responses) and DRAIN (no requests, discard responses).
- Request issue: imem_req_valid = (state==FETCH) && (count + outstanding < DEPTH) && rst. imem_req_addr = fetch_pc. On accept (valid && ready), fetch_pc += 4 and outstanding += 1. fetch_pc wraps modulo 2^32.
- Response in FETCH: the data is written to the queue tail together with its PC, and outstanding -= 1. The PC comes from a parallel PC queue or from a response-PC counter that advances by 4 per response. The credit rule guarantees the queue is never full when a response arrives, so there is no overflow.
- Queue: registered, with no same-cycle bypass. The earliest an entry is visible on out_* is the cycle after the response. out_valid = (count != 0). The head pops on out_valid && out_ready. Simultaneous push and pop keeps count unchanged.
- Redirect (redirect_valid=1 at an edge):
  - The queue is flushed. A same-cycle out handshake still completes, because the consumer already took that entry.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding after this cycle. This includes a request accepted in the same cycle and excludes a response received in the same cycle, which is discarded.
  - Next state: DRAIN if drop_cnt != 0, else FETCH.
- DRAIN: each imem_rsp_valid is discarded and decrements drop_cnt. When the last one is discarded, the next state is FETCH and requests resume the following cycle. A redirect during DRAIN updates fetch_pc and keeps counting the remaining drops.
- out_pc and out_instr are don't-care when out_valid=0. Drive them from the head entry and do not gate them.
- Counters are $clog2(DEPTH+1) bits wide. Invariant: count + outstanding <= DEPTH.

Decomposition:
- define.v gains:
  - IFU_ST_FETCH and IFU_ST_DRAIN state encodings
  - IFU_RESET_PC default constant
  - `define for the instruction width (32)
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr} with parameter DEPTH, a flush input, push/pop and count outputs, and the same clk/rst convention.
- instr_fetch_unit holds fetch_pc, outstanding, drop_cnt and the FSM.

Test Plan:
- Reset with RESET_PC=0x100, ready=1 and 1-cycle response latency -> requests 0x100, 0x104, 0x108…; out_pc/out_instr stream in order; first out_valid appears 2 cycles after the first accept.
- out_ready=0 with a constantly ready memory -> exactly 4 requests issued, imem_req_valid drops, count=4. Releasing out_ready for 1 cycle -> exactly one new request.
- 3 outstanding requests, redirect to 0x200 -> queue empty next cycle, 3 responses discarded with out_valid=0, then the next request goes to 0x200 and out_pc=0x200 is the first output.
- Redirect to 0x203 in the same cycle as a response and as an out handshake -> the response is dropped, the handshake counts, and the next fetch address is 0x200.
- Redirect during DRAIN to 0x300 with 1 drop remaining -> 1 response dropped, then fetch resumes at 0x300.
- rst=0 mid-stream for 1 cycle -> imem_req_valid=0 and out_valid=0 during reset; after release, fetch restarts at RESET_PC with an empty queue.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// queue entry layout and the fetch address helpers.
package instr_fetch_unit_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam int unsigned IFU_INSTR_W  = 32;
  localparam int unsigned IFU_PC_STEP  = 4;

  typedef enum logic {
    IFU_ST_FETCH = 1'b0,
    IFU_ST_DRAIN = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [IFU_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] ifu_word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] ifu_next_pc(input logic [31:0] pc);
    return pc + 32'(IFU_PC_STEP);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's redirect, instruction-memory and core-facing
// handshakes. The master modport is the fetch unit's view.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [31:0]            imem_req_addr;
  logic                   imem_rsp_valid;
  logic [IFU_INSTR_W-1:0] imem_rsp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [IFU_INSTR_W-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Registered in-order queue of {pc, instr} entries with synchronous flush.
// No bypass: a pushed entry appears on head_o the cycle after the push.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_entry_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch stage: credit-limited requests to instruction memory,
// in-order response queue toward the core, redirect flush with response drain.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  ifu_state_e    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW:0]   credit_used;
  logic          has_credit;
  logic          req_fire;
  logic [31:0]   redirect_aligned;

  // Queued entries plus requests in flight may never exceed DEPTH, so a
  // response always finds a free queue slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign has_credit  = credit_used < (CW+1)'(DEPTH);

  assign bus.imem_req_valid = rst && (state_q == IFU_ST_FETCH) && has_credit;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.out_valid = rst && (fifo_count != '0);
  assign bus.out_pc    = fifo_head.pc;
  assign bus.out_instr = fifo_head.instr;
  assign fifo_pop      = bus.out_valid && bus.out_ready;

  assign fifo_push = (state_q == IFU_ST_FETCH) && bus.imem_rsp_valid && !bus.redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};

  assign redirect_aligned = ifu_word_align(bus.redirect_pc);

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (bus.redirect_valid),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    case (state_q)
      IFU_ST_FETCH: begin
        if (req_fire) begin
          fetch_pc_d    = ifu_next_pc(fetch_pc_q);
          outstanding_d = outstanding_d + CW'(1);
        end
        if (bus.imem_rsp_valid) begin
          rsp_pc_d      = ifu_next_pc(rsp_pc_q);
          outstanding_d = outstanding_d - CW'(1);
        end
        // Everything still in flight after this edge belongs to the old
        // path; it moves from the credit count into the drop count.
        if (bus.redirect_valid) begin
          fetch_pc_d    = redirect_aligned;
          rsp_pc_d      = redirect_aligned;
          drop_cnt_d    = outstanding_d;
          outstanding_d = '0;
          state_d       = (drop_cnt_d != '0) ? IFU_ST_DRAIN : IFU_ST_FETCH;
        end
      end

      IFU_ST_DRAIN: begin
        if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if (bus.redirect_valid) begin
          fetch_pc_d = redirect_aligned;
          rsp_pc_d   = redirect_aligned;
        end
        if (drop_cnt_d == '0) state_d = IFU_ST_FETCH;
      end

      default: state_d = IFU_ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IFU_ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    credit_used <= (CW+1)'(DEPTH));

  a_drain_has_drops: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IFU_ST_DRAIN) |-> (drop_cnt_q != '0));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    fifo_push |-> (fifo_count < CW'(DEPTH)));

endmodule
